// File: rtl/sd_controller_wb_regs_if.sv
// Wishbone B3 classic bus bundle between a host master and the SD controller register file.
interface sd_controller_wb_regs_if;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [7:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sd_controller_wb_regs.sv
// SD controller configuration/status register file on a Wishbone classic slave port,
// with one-cycle strobes for command start and interrupt-status clear.
module sd_controller_wb_regs #(
  parameter int CMD_W         = 14,
  parameter int CMDTO_W       = 24,
  parameter int DATATO_W      = 24,
  parameter int BLKSIZE_W     = 12,
  parameter int BLKCNT_W      = 16,
  parameter int ICMD_W        = 5,
  parameter int IDATA_W       = 3,
  parameter int RESET_BLKSIZE = 511,
  parameter int RESET_CLKDIV  = 0,
  parameter int VOLTAGE_MV    = 3300
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  sd_controller_wb_regs_if.slave wb,
  output logic                 cmd_start,
  output logic                 data_int_rst,
  output logic                 cmd_int_rst,
  output logic [31:0]          argument_reg,
  output logic [CMD_W-1:0]     command_reg,
  input  logic [31:0]          response_0_reg,
  input  logic [31:0]          response_1_reg,
  input  logic [31:0]          response_2_reg,
  input  logic [31:0]          response_3_reg,
  output logic                 software_reset_reg,
  output logic                 controll_setting_reg,
  output logic [CMDTO_W-1:0]   cmd_timeout_reg,
  output logic [DATATO_W-1:0]  data_timeout_reg,
  output logic [BLKSIZE_W-1:0] block_size_reg,
  output logic [BLKCNT_W-1:0]  block_count_reg,
  output logic [7:0]           clock_divider_reg,
  output logic [31:0]          dma_addr_reg,
  input  logic [ICMD_W-1:0]    cmd_int_status_reg,
  output logic [ICMD_W-1:0]    cmd_int_enable_reg,
  input  logic [IDATA_W-1:0]   data_int_status_reg,
  output logic [IDATA_W-1:0]   data_int_enable_reg
);

  localparam logic [7:0] ADR_ARGUMENT = 8'h00;
  localparam logic [7:0] ADR_COMMAND  = 8'h04;
  localparam logic [7:0] ADR_RESP0    = 8'h08;
  localparam logic [7:0] ADR_RESP1    = 8'h0C;
  localparam logic [7:0] ADR_RESP2    = 8'h10;
  localparam logic [7:0] ADR_RESP3    = 8'h14;
  localparam logic [7:0] ADR_DATATO   = 8'h18;
  localparam logic [7:0] ADR_CTRL     = 8'h1C;
  localparam logic [7:0] ADR_CMDTO    = 8'h20;
  localparam logic [7:0] ADR_CLKDIV   = 8'h24;
  localparam logic [7:0] ADR_SWRST    = 8'h28;
  localparam logic [7:0] ADR_VOLTAGE  = 8'h2C;
  localparam logic [7:0] ADR_CAPA     = 8'h30;
  localparam logic [7:0] ADR_CMD_ISR  = 8'h34;
  localparam logic [7:0] ADR_CMD_ISER = 8'h38;
  localparam logic [7:0] ADR_DAT_ISR  = 8'h3C;
  localparam logic [7:0] ADR_DAT_ISER = 8'h40;
  localparam logic [7:0] ADR_BLKSIZE  = 8'h44;
  localparam logic [7:0] ADR_BLKCNT   = 8'h48;
  localparam logic [7:0] ADR_DMA      = 8'h60;

  logic [31:0] wmask;
  logic [31:0] rd_data;
  logic        wr_en;
  logic        rd_en;

  // Expand the byte-lane enables into a bit mask; narrow fields simply truncate the merge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[8*gi +: 8] = {8{wb.wb_sel_i[gi]}};
    end
  endgenerate

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] mask,
                                        input logic [31:0] dat);
    return (cur & ~mask) | (dat & mask);
  endfunction

  assign wr_en = wb.wb_cyc_i & wb.wb_stb_i &  wb.wb_we_i & ~wb.wb_ack_o;
  assign rd_en = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_we_i & ~wb.wb_ack_o;

  always_comb begin
    rd_data = '0;
    case (wb.wb_adr_i)
      ADR_ARGUMENT: rd_data = argument_reg;
      ADR_COMMAND:  rd_data = 32'(command_reg);
      ADR_RESP0:    rd_data = response_0_reg;
      ADR_RESP1:    rd_data = response_1_reg;
      ADR_RESP2:    rd_data = response_2_reg;
      ADR_RESP3:    rd_data = response_3_reg;
      ADR_DATATO:   rd_data = 32'(data_timeout_reg);
      ADR_CTRL:     rd_data = 32'(controll_setting_reg);
      ADR_CMDTO:    rd_data = 32'(cmd_timeout_reg);
      ADR_CLKDIV:   rd_data = 32'(clock_divider_reg);
      ADR_SWRST:    rd_data = 32'(software_reset_reg);
      ADR_VOLTAGE:  rd_data = 32'(VOLTAGE_MV);
      ADR_CAPA:     rd_data = '0;
      ADR_CMD_ISR:  rd_data = 32'(cmd_int_status_reg);
      ADR_CMD_ISER: rd_data = 32'(cmd_int_enable_reg);
      ADR_DAT_ISR:  rd_data = 32'(data_int_status_reg);
      ADR_DAT_ISER: rd_data = 32'(data_int_enable_reg);
      ADR_BLKSIZE:  rd_data = 32'(block_size_reg);
      ADR_BLKCNT:   rd_data = 32'(block_count_reg);
      ADR_DMA:      rd_data = dma_addr_reg;
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wb.wb_ack_o          <= 1'b0;
      wb.wb_dat_o          <= '0;
      cmd_start            <= 1'b0;
      cmd_int_rst          <= 1'b0;
      data_int_rst         <= 1'b0;
      argument_reg         <= '0;
      command_reg          <= '0;
      software_reset_reg   <= 1'b0;
      controll_setting_reg <= 1'b0;
      cmd_timeout_reg      <= '0;
      data_timeout_reg     <= '0;
      block_size_reg       <= BLKSIZE_W'(RESET_BLKSIZE);
      block_count_reg      <= '0;
      clock_divider_reg    <= 8'(RESET_CLKDIV);
      dma_addr_reg         <= '0;
      cmd_int_enable_reg   <= '0;
      data_int_enable_reg  <= '0;
    end else begin
      // Ack drops for at least one cycle even when the master holds cyc/stb.
      wb.wb_ack_o  <= wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
      cmd_start    <= wr_en && (wb.wb_adr_i == ADR_ARGUMENT);
      cmd_int_rst  <= wr_en && (wb.wb_adr_i == ADR_CMD_ISR);
      data_int_rst <= wr_en && (wb.wb_adr_i == ADR_DAT_ISR);
      if (rd_en) begin
        wb.wb_dat_o <= rd_data;
      end
      if (wr_en) begin
        case (wb.wb_adr_i)
          ADR_ARGUMENT: argument_reg <= merge(argument_reg, wmask, wb.wb_dat_i);
          ADR_COMMAND:
            command_reg <= CMD_W'(merge(32'(command_reg), wmask, wb.wb_dat_i));
          ADR_DATATO:
            data_timeout_reg <= DATATO_W'(merge(32'(data_timeout_reg), wmask, wb.wb_dat_i));
          ADR_CTRL:
            controll_setting_reg <= 1'(merge(32'(controll_setting_reg), wmask, wb.wb_dat_i));
          ADR_CMDTO:
            cmd_timeout_reg <= CMDTO_W'(merge(32'(cmd_timeout_reg), wmask, wb.wb_dat_i));
          ADR_CLKDIV:
            clock_divider_reg <= 8'(merge(32'(clock_divider_reg), wmask, wb.wb_dat_i));
          ADR_SWRST:
            software_reset_reg <= 1'(merge(32'(software_reset_reg), wmask, wb.wb_dat_i));
          ADR_CMD_ISER:
            cmd_int_enable_reg <= ICMD_W'(merge(32'(cmd_int_enable_reg), wmask, wb.wb_dat_i));
          ADR_DAT_ISER:
            data_int_enable_reg <= IDATA_W'(merge(32'(data_int_enable_reg), wmask, wb.wb_dat_i));
          ADR_BLKSIZE:
            block_size_reg <= BLKSIZE_W'(merge(32'(block_size_reg), wmask, wb.wb_dat_i));
          ADR_BLKCNT:
            block_count_reg <= BLKCNT_W'(merge(32'(block_count_reg), wmask, wb.wb_dat_i));
          ADR_DMA: dma_addr_reg <= merge(dma_addr_reg, wmask, wb.wb_dat_i);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_controller_wb_regs.sv
// Directed bench for sd_controller_wb_regs: bus writes checked against outputs/strobes,
// bus reads checked through an expected-value scoreboard queue.
module tb_sd_controller_wb_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start, data_int_rst, cmd_int_rst;
  logic [31:0] argument_reg;
  logic [13:0] command_reg;
  logic [31:0] response_0_reg = '0, response_1_reg = '0, response_2_reg = '0, response_3_reg = '0;
  logic        software_reset_reg, controll_setting_reg;
  logic [23:0] cmd_timeout_reg, data_timeout_reg;
  logic [11:0] block_size_reg;
  logic [15:0] block_count_reg;
  logic [7:0]  clock_divider_reg;
  logic [31:0] dma_addr_reg;
  logic [4:0]  cmd_int_status_reg = '0;
  logic [4:0]  cmd_int_enable_reg;
  logic [2:0]  data_int_status_reg = '0;
  logic [2:0]  data_int_enable_reg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  sd_controller_wb_regs_if wb();

  sd_controller_wb_regs dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb(wb),
    .cmd_start(cmd_start), .data_int_rst(data_int_rst), .cmd_int_rst(cmd_int_rst),
    .argument_reg(argument_reg), .command_reg(command_reg),
    .response_0_reg(response_0_reg), .response_1_reg(response_1_reg),
    .response_2_reg(response_2_reg), .response_3_reg(response_3_reg),
    .software_reset_reg(software_reset_reg), .controll_setting_reg(controll_setting_reg),
    .cmd_timeout_reg(cmd_timeout_reg), .data_timeout_reg(data_timeout_reg),
    .block_size_reg(block_size_reg), .block_count_reg(block_count_reg),
    .clock_divider_reg(clock_divider_reg), .dma_addr_reg(dma_addr_reg),
    .cmd_int_status_reg(cmd_int_status_reg), .cmd_int_enable_reg(cmd_int_enable_reg),
    .data_int_status_reg(data_int_status_reg), .data_int_enable_reg(data_int_enable_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] strobes();
    return {cmd_start, cmd_int_rst, data_int_rst};
  endfunction

  // Drives one request, waits (bounded) for ack, checks latency/strobes, then the ack gap.
  task automatic bus_cycle(input string tag, input logic we, input logic [7:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic [2:0] exp_strb);
    int waited = 0;
    bit got = 0;
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = dat;  wb.wb_sel_i = sel;
    while (!got && waited < 8) begin
      @(posedge clk); #1;
      waited++;
      if (wb.wb_ack_o) got = 1;
    end
    check({tag, "_ack_latency"}, 32'(waited), 32'd1);
    if (!we) begin
      sb_item_t it;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check(it.tag, wb.wb_dat_o, it.exp);
      end
    end else begin
      check({tag, "_strobe_hi"}, 32'(strobes()), 32'(exp_strb));
    end
    @(posedge clk); #1;
    check({tag, "_ack_gap"}, 32'(wb.wb_ack_o), 32'd0);
    if (we) check({tag, "_strobe_lo"}, 32'(strobes()), 32'd0);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [7:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [2:0] exp_strb);
    bus_cycle(tag, 1'b1, adr, dat, sel, exp_strb);
  endtask

  task automatic wb_read(input string tag, input logic [7:0] adr, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
    bus_cycle(tag, 1'b0, adr, 32'hA5A5A5A5, 4'h0, 3'b000);
  endtask

  initial begin
    int waited;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_dat_i = '0;   wb.wb_sel_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_ack", 32'(wb.wb_ack_o), 0);
    check("rst_argument", argument_reg, 0);
    check("rst_command", 32'(command_reg), 0);
    check("rst_blksize", 32'(block_size_reg), 511);
    check("rst_clkdiv", 32'(clock_divider_reg), 0);
    check("rst_dma", dma_addr_reg, 0);
    check("rst_strobes", 32'(strobes()), 0);
    check("rst_enables", {24'd0, cmd_int_enable_reg, data_int_enable_reg}, 0);

    wb_write("wr_arg", 8'h00, 32'h01020304, 4'hF, 3'b100);
    check("argument", argument_reg, 32'h01020304);
    check("command_untouched", 32'(command_reg), 0);

    wb_write("wr_cmd", 8'h04, 32'h0405, 4'hF, 3'b000);
    wb_write("wr_cmdto", 8'h20, 32'h0B0C, 4'hF, 3'b000);
    wb_write("wr_datato", 8'h18, 32'h0C0B, 4'hF, 3'b000);
    wb_write("wr_clkdiv", 8'h24, 32'h0D, 4'hF, 3'b000);
    wb_write("wr_ctrl", 8'h1C, 32'h1, 4'hF, 3'b000);
    wb_write("wr_swrst", 8'h28, 32'h1, 4'hF, 3'b000);
    wb_write("wr_blksize", 8'h44, 32'hABC, 4'hF, 3'b000);
    wb_write("wr_blkcnt", 8'h48, 32'h1011, 4'hF, 3'b000);
    wb_write("wr_dma", 8'h60, 32'h11121314, 4'hF, 3'b000);
    check("command", 32'(command_reg), 32'h0405);
    check("cmd_timeout", 32'(cmd_timeout_reg), 32'h0B0C);
    check("data_timeout", 32'(data_timeout_reg), 32'h0C0B);
    check("clock_divider", 32'(clock_divider_reg), 32'h0D);
    check("controll_setting", 32'(controll_setting_reg), 1);
    check("software_reset", 32'(software_reset_reg), 1);
    check("block_size", 32'(block_size_reg), 32'hABC);
    check("block_count", 32'(block_count_reg), 32'h1011);
    check("dma_addr", dma_addr_reg, 32'h11121314);
    check("argument_kept", argument_reg, 32'h01020304);

    response_0_reg = 32'h04050607; response_1_reg = 32'h05060708;
    response_2_reg = 32'h06070809; response_3_reg = 32'h0708090A;
    wb_read("rd_resp0", 8'h08, 32'h04050607);
    wb_read("rd_resp1", 8'h0C, 32'h05060708);
    wb_read("rd_resp2", 8'h10, 32'h06070809);
    wb_read("rd_resp3", 8'h14, 32'h0708090A);
    wb_read("rd_voltage", 8'h2C, 32'd3300);
    wb_read("rd_capability", 8'h30, 32'd0);
    wb_read("rd_argument", 8'h00, 32'h01020304);
    wb_read("rd_blkcnt", 8'h48, 32'h1011);

    wb_write("wr_cmd_isr", 8'h34, 32'hFFFFFFFF, 4'hF, 3'b010);
    wb_write("wr_dat_isr", 8'h3C, 32'hFFFFFFFF, 4'hF, 3'b001);
    cmd_int_status_reg = 5'h1A; data_int_status_reg = 3'h6;
    wb_read("rd_cmd_isr", 8'h34, 32'h1A);
    wb_read("rd_dat_isr", 8'h3C, 32'h6);
    wb_write("wr_cmd_iser", 8'h38, 32'h15, 4'hF, 3'b000);
    wb_write("wr_dat_iser", 8'h40, 32'h5, 4'hF, 3'b000);
    check("cmd_int_enable", 32'(cmd_int_enable_reg), 32'h15);
    check("data_int_enable", 32'(data_int_enable_reg), 32'h5);
    check("dat_o_holds", wb.wb_dat_o, 32'h6);

    wb_write("wr_dma_all", 8'h60, 32'hFFFFFFFF, 4'hF, 3'b000);
    wb_write("wr_dma_lane0", 8'h60, 32'h01020304, 4'h1, 3'b000);
    check("dma_bytesel", dma_addr_reg, 32'hFFFFFF04);
    wb_write("wr_blkcnt_all", 8'h48, 32'hFFFFFFFF, 4'hF, 3'b000);
    wb_write("wr_blkcnt_lane1", 8'h48, 32'h0, 4'h2, 3'b000);
    check("blkcnt_bytesel", 32'(block_count_reg), 32'h00FF);

    wb_write("wr_ro_voltage", 8'h2C, 32'h12345678, 4'hF, 3'b000);
    wb_read("rd_voltage_again", 8'h2C, 32'd3300);
    wb_write("wr_unmapped", 8'h4C, 32'h12345678, 4'hF, 3'b000);
    wb_read("rd_unmapped", 8'h4C, 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 0);

    // Reset asserted while the write is being acknowledged.
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 8'h00; wb.wb_dat_i = 32'hDEADBEEF; wb.wb_sel_i = 4'hF;
    waited = 0;
    while (!wb.wb_ack_o && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    check("midrst_ack_latency", 32'(waited), 1);
    check("midrst_arg_written", argument_reg, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(wb.wb_ack_o), 0);
    check("midrst_cmd_start", 32'(cmd_start), 0);
    check("midrst_argument", argument_reg, 0);
    check("midrst_blksize", 32'(block_size_reg), 511);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_dma", dma_addr_reg, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_controller_wb_regs.md
# sd_controller_wb_regs

Wishbone B3 classic slave register file for the SD card controller. Decodes 32-bit accesses from the host bus, holds the controller's configuration registers, exposes them to the command/data engines, returns response and interrupt status, and generates one-cycle strobes for command start and interrupt-status clear.

## Interface
- CMD_W, 14: command register width
- CMDTO_W, 24: command timeout width
- DATATO_W, 24: data timeout width
- BLKSIZE_W, 12: block size width
- BLKCNT_W, 16: block count width
- ICMD_W, 5: command interrupt width
- IDATA_W, 3: data interrupt width
- RESET_BLKSIZE, 511: block size reset value
- RESET_CLKDIV, 0: clock divider reset value
- VOLTAGE_MV, 3300: read-only supply voltage
- Clock and reset: one clock; reset is asynchronous and active-low.
- wb_clk_i  in  1  clock, all state on rising edge
- wb_rst_i  in  1  asynchronous active-low reset
- wb_dat_i / wb_dat_o  in/out  32  write / read data
- wb_adr_i  in  8  byte address
- wb_sel_i  in  4  byte-lane enables
- wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone controls
- wb_ack_o  out  1  acknowledge
- cmd_start, data_int_rst, cmd_int_rst  out  1 each  one-cycle strobes
- argument_reg  out  32; command_reg  out  CMD_W
- response_0_reg..response_3_reg  in  32 each  card response words
- software_reset_reg  out  1; controll_setting_reg  out  1
- cmd_timeout_reg  out  CMDTO_W; data_timeout_reg  out  DATATO_W
- block_size_reg  out  BLKSIZE_W; block_count_reg  out  BLKCNT_W
- clock_divider_reg  out  8; dma_addr_reg  out  32
- cmd_int_status_reg  in  ICMD_W; cmd_int_enable_reg  out  ICMD_W
- data_int_status_reg  in  IDATA_W; data_int_enable_reg  out  IDATA_W

## Operation
- Map (R/W unless noted): 0x00 argument, 0x04 command, 0x08/0x0C/0x10/0x14 resp0..3 (RO), 0x18 data_timeout, 0x1C controller, 0x20 cmd_timeout, 0x24 clock_divider, 0x28 software_reset, 0x2C voltage (RO, VOLTAGE_MV), 0x30 capability (RO, 0), 0x34 cmd_isr, 0x38 cmd_iser, 0x3C data_isr, 0x40 data_iser, 0x44 blksize, 0x48 blkcnt, 0x60 dma address.
- Writes: byte lane n of a register updated only if wb_sel_i[n]; fields narrower than 32 bits take the low bits of each enabled lane; unused bits ignored.
- Write to 0x00 pulses cmd_start; write to 0x34 pulses cmd_int_rst; write to 0x3C pulses data_int_rst. The data written to 0x34/0x3C is discarded; status itself is an input.
- Writes to RO or unmapped addresses are acknowledged and ignored.
- Reads: selected register zero-extended to 32 bits; isr addresses return the status inputs; unmapped addresses return 0. wb_sel_i ignored on reads.

## Timing
- Reset values: all outputs 0 except block_size_reg = RESET_BLKSIZE, clock_divider_reg = RESET_CLKDIV.
- wb_ack_o registered: ack <= cyc & stb & ~ack. Asserted one cycle after the request, high exactly one cycle, then low at least one cycle even if cyc/stb stay high.
- Write commit on the same edge that raises ack (cyc & stb & we & ~ack); register outputs valid while ack is high.
- Strobes rise on that same edge and are high for exactly one cycle; back-to-back writes give separate pulses.
- wb_dat_o registered on the edge raising ack; holds its value until the next read; status/response inputs are sampled at that edge.
- Reset mid-transfer: ack, strobes and all registers return to reset values immediately.

## Test plan
- Release reset -> all outputs 0, block_size_reg 511, clock_divider_reg 0, ack 0.
- Write 0x01020304 to 0x00 sel 0xF -> argument_reg = 0x01020304, command_reg unchanged, cmd_start one-cycle pulse; ack single cycle.
- Write 0x0405 to 0x04, 0x0B0C to 0x20, 0x0C0B to 0x18, 0x0D to 0x24, 1 to 0x1C and 0x28, 0xABC to 0x44, 0x1011 to 0x48, 0x11121314 to 0x60 -> each output equals value written.
- Drive response_0..3 = 0x04050607/0x05060708/0x06070809/0x0708090A -> reads of 0x08..0x14 return them; read 0x2C -> 3300; read 0x30 -> 0.
- Write 0x34 and 0x3C -> cmd_int_rst / data_int_rst one-cycle pulses; status inputs 0x1A / 0x6 read back; write 0x15 to 0x38, 0x5 to 0x40 -> enables 0x15 / 0x5.
- Byte select: 0xFFFFFFFF then 0x01020304 sel 0x1 to 0x60 -> 0xFFFFFF04; 0xFFFFFFFF then 0 sel 0x2 to 0x48 -> 0x00FF.
